// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: sequences fetch/decode/execute/memory
// steps, decodes the ALU operation, resolves branches from ALU flags and
// guards memory waits with a timeout that parks the FSM in ERROR.
module multicycle_control #(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  IRWrite,
  output logic                  MemReq,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALU_Control,
  output logic [3:0]            state,
  output logic                  illegal_instr,
  output logic                  bus_error
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC_R = 4'd6,  S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_TRAP   = 4'd14,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR  = 4'd3,
                         A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                         A_SRL = 4'd8, A_SRA = 4'd9;

  // Counter is wide enough to hold TIMEOUT; at least one bit when disabled.
  localparam int CW = $clog2(TIMEOUT + 2);

  state_t          cur, nxt;
  logic [CW-1:0]   wait_cnt;
  logic            wait_st, timed_out, taken;
  logic            pc_w, ir_w, mreq, mw, rw;
  logic [3:0]      alu;

  // Flag layout is {V,C,N,Z}; C=1 means no borrow, so ~C is unsigned less-than.
  function automatic logic br_taken(input logic [2:0] f3, input logic [3:0] fl);
    logic v, c, n, z;
    {v, c, n, z} = fl;
    case (f3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = ~z;
      3'b100:  br_taken = n ^ v;
      3'b101:  br_taken = ~(n ^ v);
      3'b110:  br_taken = ~c;
      3'b111:  br_taken = c;
      default: br_taken = 1'b0;
    endcase
  endfunction

  // SUB exists only for register-register ops; shifts pick SRA in both forms.
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  alu_dec = (is_r && f7) ? A_SUB : A_ADD;
      3'b001:  alu_dec = A_SLL;
      3'b010:  alu_dec = A_SLT;
      3'b011:  alu_dec = A_SLTU;
      3'b100:  alu_dec = A_XOR;
      3'b101:  alu_dec = f7 ? A_SRA : A_SRL;
      3'b110:  alu_dec = A_OR;
      default: alu_dec = A_AND;
    endcase
  endfunction

  assign state   = cur;
  assign wait_st = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  // Fires on the cycle the counter would reach TIMEOUT; mem_ready that cycle wins.
  assign timed_out = (TIMEOUT != 0) && wait_st && !mem_ready &&
                     (wait_cnt == CW'(TIMEOUT - 1));
  assign taken = br_taken(funct3, alu_flags);

  // State register, wait counter and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur           <= S_FETCH;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)                 wait_cnt <= '0;
      else if (wait_st && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (nxt == S_TRAP)  illegal_instr <= 1'b1;
      if (nxt == S_ERROR) bus_error     <= 1'b1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    nxt       = cur;
    pc_w      = 1'b0;
    ir_w      = 1'b0;
    mreq      = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    alu       = A_ADD;
    case (cur)
      S_FETCH: begin
        mreq      = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_w = 1'b1;
          pc_w = 1'b1;
          nxt  = S_DECODE;
        end else if (timed_out) begin
          nxt = S_ERROR;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        case (opcode)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_R:              nxt = S_EXEC_R;
          OP_I:              nxt = S_EXEC_I;
          OP_BR:             nxt = S_BRANCH;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
        nxt     = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mreq   = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready)      nxt = S_MEMWB;
        else if (timed_out) nxt = S_ERROR;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWR: begin
        mreq   = 1'b1;
        mw     = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready)      nxt = S_FETCH;
        else if (timed_out) nxt = S_ERROR;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        alu     = alu_dec(funct3, funct7b5, 1'b1);
        nxt     = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu     = alu_dec(funct3, funct7b5, 1'b0);
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        rw  = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu     = A_SUB;
        pc_w    = taken;
        nxt     = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
        nxt     = S_ALUWB;
      end
      default: nxt = cur; // TRAP and ERROR are terminal until reset
    endcase
  end

  // Reset abandons any access: no strobes escape while it is held.
  assign PCWrite     = pc_w & ~reset;
  assign IRWrite     = ir_w & ~reset;
  assign MemReq      = mreq & ~reset;
  assign MemWrite    = mw   & ~reset;
  assign RegWrite    = rw   & ~reset;
  assign ALU_Control = ALU_CTRL_W'(alu);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_CTRL_W, default 4, SHALL set the ALU control width; legal values are 4 or greater.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum memory-wait cycles; 0 disables the timeout.
REQ-003 Clock and reset SHALL be a single clock and an asynchronous active-high reset:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
REQ-004 Inputs SHALL be:
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- alu_flags  in  4  {V,C,N,Z}; C=1 means no borrow on subtract
- mem_ready  in  1  memory completes access this cycle
REQ-005 Outputs SHALL be:
- PCWrite  out  1
- AdrSrc  out  1  0=PC, 1=Result
- IRWrite  out  1
- MemReq  out  1
- MemWrite  out  1
- RegWrite  out  1
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=Imm, 10=const 4
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J
- ALU_Control  out  ALU_CTRL_W  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=SLT, 6=SLTU, 7=SLL, 8=SRL, 9=SRA, zero-extended
- state  out  4  current state code
- illegal_instr  out  1  sticky
- bus_error  out  1  sticky

Function
REQ-006 State codes SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=14, ERROR=15.
REQ-007 Outputs SHALL be a combinational function of state, opcode, funct3, funct7b5, alu_flags and mem_ready; any control output not listed for a state SHALL be 0.
REQ-008 FETCH SHALL drive MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10, and SHALL assert IRWrite and PCWrite only in a cycle with mem_ready=1, then go to DECODE; otherwise it SHALL hold state.
REQ-009 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ADD, and ImmSrc=J for opcode 1101111, else B.
REQ-010 DECODE SHALL branch on opcode: 0000011/0100011→MEMADR, 0110011→EXEC_R, 0010011→EXEC_I, 1100011→BRANCH, 1101111→JAL, any other→TRAP.
REQ-011 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ADD, and ImmSrc=S for stores, I for loads; it SHALL go to MEMWR for stores and MEMRD for loads.
REQ-012 MEMRD SHALL drive MemReq=1, AdrSrc=1, ResultSrc=00, and go to MEMWB on mem_ready.
REQ-013 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-014 MEMWR SHALL drive MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00, and go to FETCH on mem_ready.
REQ-015 EXEC_R (ALUSrcB=00) and EXEC_I (ALUSrcB=01, ImmSrc=I) SHALL drive ALUSrcA=10 and go to ALUWB.
REQ-016 ALU op decode from funct3 SHALL be: 000 ADD (SUB only in EXEC_R with funct7b5=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA per funct7b5 (both states), 110 OR, 111 AND.
REQ-017 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, then go to FETCH.
REQ-019 BRANCH SHALL drive PCWrite = taken, where taken is: funct3 000 Z; 001 ~Z; 100 N^V; 101 ~(N^V); 110 ~C; 111 C; 010/011 never taken.
REQ-020 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-021 A wait counter SHALL clear on entry to FETCH, MEMRD or MEMWR and SHALL increment each cycle mem_ready=0 in those states.
REQ-022 When the wait counter reaches TIMEOUT with mem_ready still 0 and TIMEOUT≠0, the FSM SHALL enter ERROR and set bus_error; mem_ready=1 in that same cycle SHALL win.
REQ-023 In TRAP and ERROR all control outputs SHALL be 0 and the FSM SHALL remain there until reset.
REQ-024 TRAP SHALL hold illegal_instr=1 and ERROR SHALL hold bus_error=1.

Reset
REQ-025 Asserting reset SHALL immediately force state=FETCH, wait counter=0 and illegal_instr=bus_error=0.
REQ-026 While reset is high all write enables and MemReq SHALL be 0; reset mid-access SHALL abandon the access without any write.

Verification
REQ-027 Bench SHALL cover lw with mem_ready=1 on every access: states 0,1,2,3,4,0, with RegWrite=1 only in state 4.
REQ-028 Bench SHALL cover sw with mem_ready held low 3 cycles in MEMWR: MemWrite high 4 cycles, then FETCH.
REQ-029 Bench SHALL cover bne with Z=1 (PCWrite=0 in BRANCH) and blt with N=1, V=0 (PCWrite=1).
REQ-030 Bench SHALL cover R-type funct3=101, funct7b5=1: ALU_Control=9; addi with funct7b5=1: ALU_Control=0.
REQ-031 Bench SHALL cover opcode 0001111: DECODE→TRAP, illegal_instr=1 until reset.
REQ-032 Bench SHALL cover TIMEOUT=16 with mem_ready=0 in FETCH: ERROR after 16 wait cycles and bus_error=1; with mem_ready=1 on cycle 16 the FSM goes to DECODE.
